// File: rtl/ula_ports_plus.sv
// ULA I/O ports: 0xFE border/EAR/MIC/keyboard, ULAplus register/data pair, palette, EAR sync, beeper LED.
// Optional: define ULAPLUS_AUTOINC_EN to auto-increment the palette index on each palette data write.
module ula_ports_plus #(
    parameter int PAL_ENTRIES     = 64,
    parameter int BEEP_DIV_BITS   = 7,
    parameter int EAR_SYNC_STAGES = 2,
    localparam int PW             = $clog2(PAL_ENTRIES)
) (
    input  logic                 clk_cpu,
    input  logic                 reset,
    input  logic [15:0]          A,
    input  logic [7:0]           D,
    input  logic                 io_we,
    output logic [7:0]           ula_data,
    input  logic [4:0]           key_row,
    input  logic                 ear_in,
    output logic [2:0]           border,
    output logic                 ear_out,
    output logic                 mic_out,
    output logic                 beeper,
    output logic                 pal_en,
    input  logic [PW-1:0]        pix_idx,
    output logic [7:0]           pix_color
);

    logic                       fe_hit, reg_hit, dat_hit;
    logic                       wr_fe, wr_reg, wr_dat, pal_wr, mode_wr;
    logic [7:0]                 reg_sel_reg;
    logic [PW-1:0]              pal_index;
    logic                       pal_grp, mode_grp;
    logic [7:0]                 palette_reg [PAL_ENTRIES];
    logic [PAL_ENTRIES-1:0]     pal_we;
    logic [EAR_SYNC_STAGES-1:0] sync_reg;
    logic                       ear_sync;
    logic [2:0]                 border_reg;
    logic                       ear_out_reg, mic_out_reg, pal_en_reg, beeper_reg;
    logic                       beep_src, beep_reg;
    logic [BEEP_DIV_BITS-1:0]   beep_cnt_reg;
    logic [7:0]                 pix_color_reg;

    // REG and DAT are full 16-bit matches on odd addresses, so they never collide with FE.
    assign fe_hit  = ~A[0];
    assign reg_hit = (A == 16'hBF3B);
    assign dat_hit = (A == 16'hFF3B);

    assign wr_fe   = io_we & fe_hit;
    assign wr_reg  = io_we & reg_hit;
    assign wr_dat  = io_we & dat_hit;

    assign pal_index = reg_sel_reg[PW-1:0];
    assign pal_grp   = (reg_sel_reg[7:6] == 2'b00);
    assign mode_grp  = (reg_sel_reg[7:6] == 2'b01);
    assign pal_wr    = wr_dat & pal_grp;
    assign mode_wr   = wr_dat & mode_grp;
    assign ear_sync  = sync_reg[EAR_SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < PAL_ENTRIES; gi++) begin : g_pal_we
            assign pal_we[gi] = pal_wr && (pal_index == PW'(gi));
        end
    endgenerate

    // Palette is cleared on reset, so it is built from registers rather than block RAM.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            for (int i = 0; i < PAL_ENTRIES; i++) palette_reg[i] <= '0;
            pix_color_reg <= '0;
        end else begin
            for (int i = 0; i < PAL_ENTRIES; i++)
                if (pal_we[i]) palette_reg[i] <= D;
            pix_color_reg <= palette_reg[pix_idx];
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            reg_sel_reg <= '0;
            border_reg  <= '0;
            ear_out_reg <= 1'b0;
            mic_out_reg <= 1'b0;
            pal_en_reg  <= 1'b0;
        end else begin
            if (wr_fe) begin
                border_reg  <= D[2:0];
                ear_out_reg <= D[4];
                mic_out_reg <= D[3];
            end
            if (wr_reg)
                reg_sel_reg <= D;
`ifdef ULAPLUS_AUTOINC_EN
            else if (pal_wr)
                reg_sel_reg[PW-1:0] <= pal_index + PW'(1);
`endif
            if (mode_wr)
                pal_en_reg <= D[0];
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            sync_reg     <= '0;
            beep_reg     <= 1'b0;
            beep_cnt_reg <= '0;
            beeper_reg   <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[EAR_SYNC_STAGES-2:0], ear_in};
            beep_reg <= beep_src;
            if (beep_src && !beep_reg) begin
                beep_cnt_reg <= beep_cnt_reg + BEEP_DIV_BITS'(1);
                if (&beep_cnt_reg) beeper_reg <= ~beeper_reg;
            end
        end
    end

    assign beep_src = ear_sync ^ ear_out_reg ^ mic_out_reg;

    always_comb begin
        ula_data = 8'hFF;
        if (fe_hit)
            ula_data = {1'b1, ear_sync, 1'b1, key_row};
        else if (reg_hit)
            ula_data = reg_sel_reg;
        else if (dat_hit) begin
            if (pal_grp)
                ula_data = palette_reg[pal_index];
            else if (mode_grp)
                ula_data = {7'b0, pal_en_reg};
        end
    end

    assign border    = border_reg;
    assign ear_out   = ear_out_reg;
    assign mic_out   = mic_out_reg;
    assign pal_en    = pal_en_reg;
    assign beeper    = beeper_reg;
    assign pix_color = pix_color_reg;

endmodule

// File: tb/tb_ula_ports_plus.sv
// Directed bench for ula_ports_plus; expected values adapt to ULAPLUS_AUTOINC_EN.
module tb_ula_ports_plus;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  D;
    logic        io_we;
    logic [7:0]  ula_data;
    logic [4:0]  key_row;
    logic        ear_in;
    logic [2:0]  border;
    logic        ear_out, mic_out, beeper, pal_en;
    logic [5:0]  pix_idx;
    logic [7:0]  pix_color;

    int checks = 0;
    int errors = 0;

    always #5 clk_cpu = ~clk_cpu;

    ula_ports_plus dut (
        .clk_cpu   (clk_cpu),
        .reset     (reset),
        .A         (A),
        .D         (D),
        .io_we     (io_we),
        .ula_data  (ula_data),
        .key_row   (key_row),
        .ear_in    (ear_in),
        .border    (border),
        .ear_out   (ear_out),
        .mic_out   (mic_out),
        .beeper    (beeper),
        .pal_en    (pal_en),
        .pix_idx   (pix_idx),
        .pix_color (pix_color)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_cpu);
        #1;
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input bit show = 1'b1);
        A = addr; D = data; io_we = 1'b1;
        @(posedge clk_cpu);
        #1;
        io_we = 1'b0;
        if (show) $display("WR  A=%h D=%h", addr, data);
    endtask

    task automatic read_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        A = addr; io_we = 1'b0;
        #1;
        $display("RD  A=%h data=%h", addr, ula_data);
        check(tag, ula_data, exp);
    endtask

    task automatic pix_chk(input string tag, input logic [5:0] idx, input logic [7:0] exp);
        pix_idx = idx;
        @(posedge clk_cpu);
        #1;
        $display("PIX idx=%0d color=%h", idx, pix_color);
        check(tag, pix_color, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset while a write is pending on FE: reset must win
        reset = 1'b1; io_we = 1'b1; A = 16'h00FE; D = 8'hFF;
        key_row = 5'b11111; ear_in = 1'b0; pix_idx = '0;
        cycles(3);
        reset = 1'b0; io_we = 1'b0; A = 16'h0001;
        check("rst_border", border, 3'd0);
        check("rst_ear", ear_out, 1'b0);
        check("rst_mic", mic_out, 1'b0);
        check("rst_pal_en", pal_en, 1'b0);
        check("rst_beeper", beeper, 1'b0);
        check("rst_pix", pix_color, 8'h00);
        read_chk("rst_regsel", 16'hBF3B, 8'h00);
        for (int i = 0; i < 64; i++) pix_chk("rst_palette", 6'(i), 8'h00);

        // FE port write and keyboard/EAR read-back
        io_write(16'h00FE, 8'h1D);
        check("fe_border", border, 3'd5);
        check("fe_ear", ear_out, 1'b1);
        check("fe_mic", mic_out, 1'b1);
        key_row = 5'b10110; ear_in = 1'b1;
        cycles(2);
        read_chk("fe_read_ear1", 16'h7FFE, 8'hF6);
        ear_in = 1'b0;
        cycles(1);
        read_chk("ear_latency1", 16'h7FFE, 8'hF6);
        cycles(1);
        read_chk("ear_latency2", 16'h7FFE, 8'hB6);
        read_chk("default_read", 16'h1235, 8'hFF);
        read_chk("near_miss_read", 16'h7F3B, 8'hFF);

        // ULAplus palette and mode registers
        io_write(16'hBF3B, 8'h05);
        io_write(16'hFF3B, 8'hE3);
        io_write(16'hBF3B, 8'h40);
        io_write(16'hFF3B, 8'h01);
        check("mode_pal_en", pal_en, 1'b1);
        read_chk("mode_read", 16'hFF3B, 8'h01);
        read_chk("reg_read_40", 16'hBF3B, 8'h40);
        io_write(16'hBF3B, 8'h05);
        read_chk("pal_read5", 16'hFF3B, 8'hE3);
        read_chk("pal_read_noinc", 16'hBF3B, 8'h05);
        pix_chk("pix5", 6'd5, 8'hE3);

        // Unused group code: stored, data writes ignored, data reads default
        io_write(16'hBF3B, 8'h85);
        read_chk("grp2_read", 16'hFF3B, 8'hFF);
        io_write(16'hFF3B, 8'h77);
        read_chk("grp2_regsel", 16'hBF3B, 8'h85);
        check("grp2_pal_en", pal_en, 1'b1);
        io_write(16'hBF3B, 8'h05);
        read_chk("grp2_ignored", 16'hFF3B, 8'hE3);

        // Non-decoded write leaves everything alone
        io_write(16'h7F3B, 8'h07);
        check("nodec_border", border, 3'd5);
        read_chk("nodec_regsel", 16'hBF3B, 8'h05);

        // Video read collides with CPU write: old value first, new value next cycle
        pix_idx = 6'd9;
        io_write(16'hBF3B, 8'h09);
        cycles(1);
        check("coll_before", pix_color, 8'h00);
        A = 16'hFF3B; D = 8'h1C; io_we = 1'b1;
        @(posedge clk_cpu);
        #1;
        io_we = 1'b0;
        $display("WR  A=%h D=%h (pix_idx=9)", 16'hFF3B, 8'h1C);
        check("coll_old", pix_color, 8'h00);
        @(posedge clk_cpu);
        #1;
        check("coll_new", pix_color, 8'h1C);
`ifdef ULAPLUS_AUTOINC_EN
        read_chk("coll_dat_after", 16'hFF3B, 8'h00);
`else
        read_chk("coll_dat_after", 16'hFF3B, 8'h1C);
`endif

        // Index wrap with consecutive palette data writes
        io_write(16'hBF3B, 8'h3F);
        io_write(16'hFF3B, 8'hAA);
        io_write(16'hFF3B, 8'hBB);
`ifdef ULAPLUS_AUTOINC_EN
        read_chk("wrap_regsel", 16'hBF3B, 8'h01);
        pix_chk("wrap_pal63", 6'd63, 8'hAA);
        pix_chk("wrap_pal0", 6'd0, 8'hBB);
`else
        read_chk("wrap_regsel", 16'hBF3B, 8'h3F);
        pix_chk("wrap_pal63", 6'd63, 8'hBB);
        pix_chk("wrap_pal0", 6'd0, 8'h00);
`endif

        // Second reset clears palette and registers
        reset = 1'b1; io_we = 1'b1; A = 16'h00FE; D = 8'hFF;
        cycles(2);
        reset = 1'b0; io_we = 1'b0; A = 16'h0001;
        check("rst2_pal_en", pal_en, 1'b0);
        check("rst2_border", border, 3'd0);
        read_chk("rst2_regsel", 16'hBF3B, 8'h00);
        pix_chk("rst2_pal5", 6'd5, 8'h00);

        // Beeper divider: 127 edges no toggle, 128 toggles, 256 back to 0
        for (int i = 0; i < 127; i++) begin
            io_write(16'h00FE, 8'h10, 1'b0);
            io_write(16'h00FE, 8'h00, 1'b0);
        end
        cycles(2);
        $display("BEEP edges=127 beeper=%0b", beeper);
        check("beep_127", beeper, 1'b0);
        io_write(16'h00FE, 8'h10, 1'b0);
        io_write(16'h00FE, 8'h00, 1'b0);
        cycles(2);
        $display("BEEP edges=128 beeper=%0b", beeper);
        check("beep_128", beeper, 1'b1);
        for (int i = 0; i < 128; i++) begin
            io_write(16'h00FE, 8'h10, 1'b0);
            io_write(16'h00FE, 8'h00, 1'b0);
        end
        cycles(2);
        $display("BEEP edges=256 beeper=%0b", beeper);
        check("beep_256", beeper, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_ports_plus.md
Name: ula_ports_plus

Overview:
Parametrised successor to the ULA I/O port logic. It handles the standard 0xFE port: border, EAR/MIC outputs, and keyboard/EAR read-back. It adds a ULAplus-compatible register/data port pair (0xBF3B / 0xFF3B), a palette register file read by the video subsystem, a synchronised EAR input and a parametrised beeper-activity LED divider. It sits in the ULA between the CPU bus and the video/keyboard/audio blocks, clocked on the CPU clock.

Parameters:
PAL_ENTRIES  64  palette depth; power of two, 16..64; index width PW = log2(PAL_ENTRIES)
BEEP_DIV_BITS  7  beeper LED toggles once per 2^BEEP_DIV_BITS rising edges of the beep source
EAR_SYNC_STAGES  2  flip-flop stages on ear_in; minimum 2

Ports:
clk_cpu  in  1  CPU clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
A  in  16  CPU address bus
D  in  8  CPU write data
io_we  in  1  I/O write strobe; one write per cycle while high
ula_data  out  8  I/O read data; combinational from registers
key_row  in  5  active-low keyboard row data from the keyboard matrix
ear_in  in  1  asynchronous tape EAR input
border  out  3  border colour index
ear_out  out  1  EAR (speaker) bit
mic_out  out  1  MIC bit
beeper  out  1  activity LED
pal_en  out  1  ULAplus palette mode enabled
pix_idx  in  PW  video palette lookup index
pix_color  out  8  palette entry for pix_idx, GRB 3:3:2; registered

Behaviour:
- Reset (synchronous, reset=1 at a clk_cpu edge) clears the following:
  - border=0, ear_out=0, mic_out=0, pal_en=0, beeper=0, pix_color=0.
  - Internal state: reg_sel=0, beep counter=0, synchroniser=0.
  - All palette entries = 0.
- Reset overrides any same-cycle io_we.
- Port decode:
  - FE: A[0]==0.
  - REG: A==16'hBF3B.
  - DAT: A==16'hFF3B.
  - REG and DAT are exact 16-bit matches with A[0]=1, so they never overlap FE.
- FE write (io_we & FE): border<=D[2:0], ear_out<=D[4], mic_out<=D[3].
- REG write: reg_sel<=D.
  - D[7:6]==2'b00 selects the palette group; index = D[PW-1:0].
  - D[7:6]==2'b01 selects the mode group.
  - Other group codes are stored but DAT writes to them are ignored.
- DAT write:
  - Palette group: palette[index]<=D.
  - Mode group: pal_en<=D[0].
- Reads:
  - ula_data defaults to 8'hFF.
  - FE: {1'b1, ear_sync, 1'b1, key_row}.
  - DAT with palette group: palette[index].
  - DAT with mode group: {7'b0, pal_en}.
  - REG: reg_sel.
- ear_sync: ear_in after EAR_SYNC_STAGES flops, giving latency of EAR_SYNC_STAGES cycles.
- Video read port: pix_color <= palette[pix_idx] every cycle, 1-cycle latency.
  - If a CPU write hits the same index in the same cycle, pix_color returns the old value; the new value appears on the next cycle (read-before-write).
- Beeper LED:
  - Beep source: beep = ear_sync ^ ear_out ^ mic_out, registered.
  - On each 0->1 transition of beep the counter increments.
  - When the counter wraps from all-ones to 0, beeper toggles.
  - Counter width is BEEP_DIV_BITS; it wraps freely.
- Writes to non-decoded addresses have no effect.
- Back-to-back io_we cycles each perform one write.

Optional Feature:
- Macro: ULAPLUS_AUTOINC_EN.
- Defined:
  - Each DAT write in the palette group increments reg_sel's index field modulo PAL_ENTRIES; reg_sel[7:6] is unchanged.
  - The wrap is PAL_ENTRIES-1 -> 0.
  - Mode-group writes never increment.
  - DAT reads do not increment.
- Undefined: the index changes only via REG writes.

Test Plan:
- Reset with io_we=1, A=16'h00FE, D=8'hFF -> border=0, ear_out=0, mic_out=0, pal_en=0, beeper=0; all palette entries read 0.
- io_we on A=16'h00FE, D=8'h1D -> border=5, ear_out=1, mic_out=1. Read A=16'h7FFE with key_row=5'b10110, ear_in=1 held 2+ cycles -> ula_data=8'hF6.
- REG write 8'h05, DAT write 8'hE3, REG write 8'h40, DAT write 8'h01 -> pal_en=1. Then REG write 8'h05 and read DAT -> 8'hE3; pix_idx=5 -> pix_color=8'hE3 one cycle later.
- Same-cycle CPU write of 8'h1C to index 9 while pix_idx=9 (old value 8'h00) -> pix_color=8'h00 that cycle, then 8'h1C the next cycle.
- With ULAPLUS_AUTOINC_EN: REG write 8'h3F, DAT writes 8'hAA then 8'hBB -> palette[63]=8'hAA, palette[0]=8'hBB, REG read=8'h01. Without the macro: palette[63]=8'hBB, REG read=8'h3F.
- 128 rising edges of beep via alternating FE writes of D[4] (BEEP_DIV_BITS=7) -> beeper toggles exactly once; 256 edges -> beeper back to 0.
